flash_bitstream_reader: RTL

FLASH_BITSTREAM_READER -- requirements
Module: flash_bitstream_reader

---
 rtl/flash_pkg.sv | 20 ++
 rtl/spi_shift_reg.sv | 32 +++
 rtl/flash_bitstream_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash bitstream reader: address width, default
// read opcode and the controller state encoding.
package flash_pkg;

  localparam int ADDR_W = 24;
  localparam int SHIFT_W = 8 + ADDR_W;
  localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_FLUSH,
    S_END,
    S_HOLD
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial shifter: parallel-load with MSB-first serial output, and serial-in
// capture whose low CAP_W bits are exposed as the received data.
module spi_shift_reg #(
  parameter int WIDTH = 32,
  parameter int CAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic [CAP_W-1:0] capture
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = sreg[WIDTH-1];
  assign capture    = sreg[CAP_W-1:0];

endmodule

// File: rtl/flash_bitstream_reader.sv
// Streams a channel bitstream out of SPI flash (READ opcode + 24-bit address).
// Define BIT_SWAP_EN to emit each byte LSB first through a byte buffer.
module flash_bitstream_reader
  import flash_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 24'hCE0000,
  parameter logic [ADDR_W-1:0] NUM_BYTES  = 24'd4194304,
  parameter logic [7:0]        CMD_READ   = CMD_READ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic store_cmd,
  input  logic read_start,
  output logic spi_csn,
  output logic spi_sck_en,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic bitstream,
  output logic end_bitstream,
  output logic busy
);

`ifdef BIT_SWAP_EN
  localparam int CAP_W = 8;
`else
  localparam int CAP_W = 1;
`endif

  state_t state, next_state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic bit_last, count_run, end_q;
  logic shift_msb;
  logic [CAP_W-1:0] capture;

  assign bit_last = (bit_cnt == 3'd7);

`ifdef BIT_SWAP_EN
  logic [7:0] swap_buf;
  logic [2:0] swap_cnt;
  logic swap_valid, byte_done_d, flush_done;

  // The last buffered byte is on its 7th bit, so END carries its 8th.
  assign flush_done = !byte_done_d && swap_valid && (swap_cnt == 3'd6);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (store_cmd) next_state = S_ARMED;
      S_ARMED: if (read_start) next_state = S_CMD;
      S_CMD: begin
        if (!read_start) next_state = S_IDLE;
        else if (bit_last) next_state = S_ADDR;
      end
      S_ADDR: begin
        if (!read_start) next_state = S_IDLE;
        else if (bit_last && byte_cnt == 24'd3) next_state = S_DATA;
      end
      S_DATA: begin
        if (!read_start) next_state = S_IDLE;
`ifdef BIT_SWAP_EN
        else if (bit_last && byte_cnt == NUM_BYTES - 24'd1) next_state = S_FLUSH;
`else
        else if (bit_last && byte_cnt == NUM_BYTES - 24'd1) next_state = S_END;
`endif
      end
      S_FLUSH: begin
        if (!read_start) next_state = S_IDLE;
`ifdef BIT_SWAP_EN
        else if (flush_done) next_state = S_END;
`else
        else next_state = S_END;
`endif
      end
      S_END:  next_state = S_HOLD;
      S_HOLD: if (!read_start) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    spi_csn    = 1'b1;
    spi_sck_en = 1'b0;
    spi_mosi   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_CMD, S_ADDR: begin
        spi_csn    = 1'b0;
        spi_sck_en = 1'b1;
        spi_mosi   = shift_msb;
      end
      S_DATA: begin
        spi_csn    = 1'b0;
        spi_sck_en = 1'b1;
      end
      default: ;
    endcase
  end

  // One counter pair times CMD (byte 0), ADDR (bytes 1..3) and DATA.
  assign count_run = (state inside {S_CMD, S_ADDR, S_DATA}) &&
                     ((next_state == state) || (state == S_CMD && next_state == S_ADDR));

  always_ff @(posedge clk) begin
    if (reset || !count_run) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_last) byte_cnt <= byte_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      end_q    <= 1'b0;
    end else begin
      if ((state == S_IDLE || state == S_ARMED) && store_cmd) addr_reg <= START_ADDR;
      end_q <= (state == S_END);
    end
  end

  assign end_bitstream = end_q;

  spi_shift_reg #(
    .WIDTH (SHIFT_W),
    .CAP_W (CAP_W)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (state == S_ARMED && read_start),
    .shift_en   (state inside {S_CMD, S_ADDR, S_DATA}),
    .serial_in  (spi_miso),
    .load_data  ({CMD_READ, addr_reg}),
    .serial_out (shift_msb),
    .capture    (capture)
  );

`ifdef BIT_SWAP_EN
  // A completed byte is copied out of the shifter one cycle later, then
  // drained LSB first while the shifter already collects the next byte.
  always_ff @(posedge clk) begin
    if (reset || next_state == S_IDLE) begin
      byte_done_d <= 1'b0;
      swap_valid  <= 1'b0;
      swap_cnt    <= '0;
      swap_buf    <= '0;
    end else begin
      byte_done_d <= (state == S_DATA) && bit_last;
      if (byte_done_d) begin
        swap_buf   <= capture;
        swap_cnt   <= '0;
        swap_valid <= 1'b1;
      end else if (swap_valid) begin
        swap_buf <= {1'b0, swap_buf[7:1]};
        swap_cnt <= swap_cnt + 3'd1;
        if (swap_cnt == 3'd7) swap_valid <= 1'b0;
      end
    end
  end

  assign bitstream = swap_valid ? swap_buf[0] : 1'b1;
`else
  logic data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_d <= 1'b0;
    end else begin
      data_d <= (state == S_DATA) && (next_state != S_IDLE);
    end
  end

  assign bitstream = data_d ? capture[0] : 1'b1;
`endif

endmodule
